// File: rtl/binary_bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
// Working width and add-3 threshold for the double-dabble network.
package binary_bcd_pkg;

  typedef logic [3:0] bcd_t;

  localparam int WORK_W  = 6;
  localparam int DIGIT_W = 4;
  localparam int SR_W    = WORK_W + 2 * DIGIT_W;

  localparam bcd_t ADD3_TH = 4'd5;
  localparam bcd_t ADD3_K  = 4'd3;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble cell: adds 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_add3
  import binary_bcd_pkg::*;
(
  input  logic [3:0] in,
  output logic [3:0] out
);

  always_comb begin
    out = in;
    if (in >= ADD3_TH)
      out = in + ADD3_K;
  end

endmodule

// File: rtl/binary_to_bcd.sv
// Registered binary-to-BCD converter (two digits, double-dabble).
// Optional range_err output: define BINARY_BCD_RANGE_CHECK_EN.
module binary_to_bcd
  import binary_bcd_pkg::*;
#(
  parameter int BIN_W   = 5,
  parameter int MAX_VAL = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [BIN_W-1:0] bin,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic             out_valid
`ifdef BINARY_BCD_RANGE_CHECK_EN
  ,
  output logic             range_err
`endif
);

  logic [WORK_W-1:0]          bin_ext;
  logic [WORK_W:0][SR_W-1:0]  stage;
  logic [WORK_W-1:0][SR_W-1:0] adj;
  logic [WORK_W-1:0]          drop_msb;
  bcd_t                       tens_c;
  bcd_t                       ones_c;
  logic                       unused_ok;

  assign bin_ext  = WORK_W'(bin);
  assign stage[0] = {{(2 * DIGIT_W){1'b0}}, bin_ext};

  for (genvar i = 0; i < WORK_W; i++) begin : g_iter
    for (genvar n = 0; n < 2; n++) begin : g_dig
      bcd_add3 u_add3 (
        .in  (stage[i][WORK_W + DIGIT_W * n +: DIGIT_W]),
        .out (adj[i][WORK_W + DIGIT_W * n +: DIGIT_W])
      );
    end
    assign adj[i][WORK_W-1:0] = stage[i][WORK_W-1:0];
    // Inputs never exceed 63, so the bit shifted out of tens is always 0.
    assign drop_msb[i]  = adj[i][SR_W-1];
    assign stage[i + 1] = {adj[i][SR_W-2:0], 1'b0};
  end

  assign tens_c    = stage[WORK_W][SR_W-1 -: DIGIT_W];
  assign ones_c    = stage[WORK_W][WORK_W +: DIGIT_W];
  assign unused_ok = ^{drop_msb, stage[WORK_W][WORK_W-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_tens  <= '0;
      bcd_ones  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        bcd_tens <= tens_c;
        bcd_ones <= ones_c;
      end
    end
  end

`ifdef BINARY_BCD_RANGE_CHECK_EN
  localparam logic [WORK_W-1:0] MAX_W = WORK_W'(MAX_VAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      range_err <= 1'b0;
    else if (in_valid)
      range_err <= (bin_ext > MAX_W);
  end
`endif

endmodule

// File: tb/tb_binary_to_bcd.sv
// Directed table-driven bench for binary_to_bcd.
// Range checks are active when BINARY_BCD_RANGE_CHECK_EN is defined.
module tb_binary_to_bcd;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [4:0] bin;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       out_valid;
  logic       range_err;

  int n_vec;
  int n_err;

  typedef struct {
    logic       vld;
    logic [4:0] bin;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       ov;
    logic       rerr;
  } vec_t;

  vec_t tbl [11];

  binary_to_bcd #(
    .BIN_W   (5),
    .MAX_VAL (19)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .bin       (bin),
    .bcd_tens  (bcd_tens),
    .bcd_ones  (bcd_ones),
    .out_valid (out_valid)
`ifdef BINARY_BCD_RANGE_CHECK_EN
    ,
    .range_err (range_err)
`endif
  );

`ifndef BINARY_BCD_RANGE_CHECK_EN
  assign range_err = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] t,
                       input logic [3:0] o, input logic v,
                       input logic r);
    logic ok;
    n_vec++;
    ok = (bcd_tens === t) && (bcd_ones === o) && (out_valid === v);
`ifdef BINARY_BCD_RANGE_CHECK_EN
    ok = ok && (range_err === r);
`endif
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got tens=%0d ones=%0d ov=%b re=%b, want tens=%0d ones=%0d ov=%b re=%b",
               name, bcd_tens, bcd_ones, out_valid, range_err, t, o, v, r);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    bin      = '0;

    tbl[0]  = '{1'b1, 5'd0,  4'd0, 4'd0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 5'd1,  4'd0, 4'd1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 5'd19, 4'd1, 4'd9, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 5'd8,  4'd0, 4'd8, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 5'd10, 4'd1, 4'd0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 5'd19, 4'd1, 4'd9, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 5'd7,  4'd1, 4'd9, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 5'd20, 4'd2, 4'd0, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 5'd3,  4'd2, 4'd0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 5'd31, 4'd3, 4'd1, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 5'd19, 4'd1, 4'd9, 1'b1, 1'b0};

    step();
    step();
    check("reset_state", 4'd0, 4'd0, 1'b0, 1'b0);

    rst      = 1'b0;
    in_valid = 1'b1;
    bin      = 5'd12;
    step();
    check("first_edge_12", 4'd1, 4'd2, 1'b1, 1'b0);

    for (int i = 0; i < 11; i++) begin
      in_valid = tbl[i].vld;
      bin      = tbl[i].bin;
      step();
      check($sformatf("tbl_%0d", i), tbl[i].tens, tbl[i].ones,
            tbl[i].ov, tbl[i].rerr);
    end

    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1;
      bin      = 5'(i);
      step();
      check($sformatf("sweep_%0d", i), 4'(i / 10), 4'(i % 10),
            1'b1, (i > 19));
      n_vec++;
      if (bcd_tens > 4'd9 || bcd_ones > 4'd9) begin
        n_err++;
        $display("FAIL digit_range_%0d: got tens=%0d ones=%0d, want both <= 9",
                 i, bcd_tens, bcd_ones);
      end
    end

    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 4'd0, 4'd0, 1'b0, 1'b0);

    in_valid = 1'b1;
    bin      = 5'd9;
    step();
    check("reset_held", 4'd0, 4'd0, 1'b0, 1'b0);

    rst = 1'b0;
    bin = 5'd12;
    step();
    check("release_12", 4'd1, 4'd2, 1'b1, 1'b0);

    in_valid = 1'b0;
    bin      = 5'd25;
    step();
    check("no_valid_hold", 4'd1, 4'd2, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/binary_to_bcd.md
# binary_to_bcd

Registered binary-to-BCD converter that turns an unsigned binary count into two packed BCD digits (tens, ones) for seven-segment display decode. It sits between the 0–19 counter core and the per-digit display drivers. Conversion uses the shift-and-add-3 (double-dabble) algorithm, evaluated combinationally and captured in an output register.

## Interface
Parameters:
- BIN_W, default 5: width of the binary input. Legal range is 1–6, so any value fits in two decimal digits (max 63).
- MAX_VAL, default 19: highest value the counter is allowed to produce. Used only by the range check (see Configuration).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies `bin` for capture on this clock edge.
- bin  input  BIN_W  unsigned binary value to convert.
- bcd_tens  output  4  BCD tens digit, registered; range 0–6.
- bcd_ones  output  4  BCD ones digit, registered; range 0–9.
- out_valid  output  1  registered copy of in_valid, delayed one cycle.
- range_err  output  1  registered; present only when BINARY_BCD_RANGE_CHECK_EN is defined.

## Operation
- Combinational stage: zero-extend `bin` to 6 bits, then run 6 double-dabble iterations. Before each shift, add 3 to any BCD nibble that is ≥5. This yields tens = bin/10 and ones = bin%10.
- Register stage: on a rising clk edge with in_valid=1, capture the new digits. With in_valid=0, bcd_tens and bcd_ones hold their previous values.
- out_valid is updated every cycle with the value in_valid had on that edge.
- Every bin value is convertible. No digit ever exceeds 9, and bcd_tens never exceeds 6.
- Packed form {bcd_tens, bcd_ones} is the display-ready 8-bit BCD value.

## Timing
- Latency is exactly 1 clock: the value on `bin` at edge N (in_valid=1) appears on the outputs after edge N and is stable until the next qualified edge.
- Throughput is one conversion per clock, with no back-pressure and no stall.
- Reset: bcd_tens=0, bcd_ones=0, out_valid=0, range_err=0. Reset takes effect immediately on rst high, independent of clk.
- Deasserting rst mid-stream: the first capture happens on the first rising edge at which rst=0 and in_valid=1.
- An input change without in_valid has no effect on the outputs.

## Configuration
- BINARY_BCD_RANGE_CHECK_EN defined:
  - The range_err port exists.
  - On each qualified capture, range_err is registered as (bin > MAX_VAL).
  - The digits are still the true conversion; nothing saturates.
  - range_err holds while in_valid=0.
- BINARY_BCD_RANGE_CHECK_EN undefined:
  - The range_err port and its logic are absent.
  - All other behaviour is identical.

## Structure
- Package `binary_bcd_pkg` holds:
  - typedef for a 4-bit BCD digit.
  - constant for the internal working width (6).
  - constant for the add-3 threshold (5).
- One sub-module, `bcd_add3`: a 4-bit nibble cell that outputs in+3 when in≥5, else in unchanged. It is instantiated per nibble per iteration through generate loops.
- Top-level `binary_to_bcd` contains the generate array and the output/valid/range registers.

## Test plan
- Reset asserted asynchronously mid-clock with outputs nonzero -> bcd_tens=0, bcd_ones=0, out_valid=0 immediately.
- Drive bin=0, 1, 19, 8, 10 on consecutive cycles with in_valid=1 -> one cycle later each, the tens/ones pairs are 0/0, 0/1, 1/9, 0/8, 1/0, and out_valid=1 throughout.
- Sweep bin=0..31 exhaustively -> every result has tens=bin/10 and ones=bin%10, and no digit exceeds 9.
- Drive bin=19, then change bin to 7 with in_valid=0 -> outputs hold 1/9 and out_valid=0.
- With BINARY_BCD_RANGE_CHECK_EN defined: bin=19 -> range_err=0; bin=20 -> range_err=1 with digits 2/0; bin=31 -> range_err=1 with digits 3/1.
- Reset released, then bin=12 applied with in_valid=1 on the first edge -> 1/2 appears after that edge.
